// File: rtl/adv7513_reg_scan.sv
// adv7513_reg_scan: walks an inclusive ADV7513 register range through the
// single-register read block (rd_start/rd_addr/rd_done handshake) and
// captures each returned byte into a 256x8 buffer read back via rb_addr.
// Optional build macro: ADV7513_SCAN_TIMEOUT_EN (per-transaction watchdog).
module adv7513_reg_scan #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_start,
  input  logic [7:0] first_addr,
  input  logic [7:0] last_addr,
  output logic       busy,
  output logic       scan_done,
  output logic       range_err,
  output logic       timeout_err,
  output logic [8:0] rd_count,
  output logic       rd_start,
  output logic [7:0] rd_addr,
  input  logic       rd_done,
  input  logic [7:0] rd_data,
  input  logic [7:0] rb_addr,
  output logic [7:0] rb_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] cur_addr;
  logic [7:0] end_addr;
  logic [7:0] offset;
  logic [7:0] store_data;
  logic       tmo;
  logic       tmo_hit;
  logic [7:0] mem [0:255];

  // The read block sees the current address directly; it only moves in S_STORE.
  assign rd_addr = cur_addr;

`ifdef ADV7513_SCAN_TIMEOUT_EN
  logic [23:0] wd_cnt;
  logic        store_ff;

  assign tmo        = (wd_cnt >= (TIMEOUT_CYCLES - 24'd1));
  assign store_data = store_ff ? 8'hFF : rd_data;

  // Watchdog: cleared on entry to S_ISSUE, counts while a transaction is open.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt   <= '0;
      store_ff <= 1'b0;
    end else begin
      if (state != S_ISSUE && state_next == S_ISSUE)
        wd_cnt <= '0;
      else if (state == S_ISSUE || state == S_ARM || state == S_WAIT)
        wd_cnt <= wd_cnt + 24'd1;
      if (state_next == S_STORE)
        store_ff <= tmo_hit;
    end
  end

  // Sticky watchdog flag, cleared when a new scan is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      timeout_err <= 1'b0;
    else if (state == S_IDLE && scan_start)
      timeout_err <= 1'b0;
    else if (tmo_hit)
      timeout_err <= 1'b1;
  end
`else
  // Parameter is kept for port compatibility; it has no function here.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo         = 1'b0;
  assign store_data  = rd_data;
  assign timeout_err = 1'b0;
`endif

  // Timeout only matters when the normal handshake condition is not met.
  always_comb begin
    tmo_hit = tmo && ((((state == S_ISSUE) || (state == S_WAIT)) && !rd_done) ||
                      ((state == S_ARM) && rd_done));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; S_ARM ignores the still-high rd_done right after rd_start.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (scan_start) state_next = (first_addr > last_addr) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (rd_done)      state_next = S_ARM;
        else if (tmo_hit) state_next = S_DONE;
      end
      S_ARM: begin
        if (!rd_done)     state_next = S_WAIT;
        else if (tmo_hit) state_next = S_STORE;
      end
      S_WAIT:  if (rd_done || tmo_hit) state_next = S_STORE;
      S_STORE: state_next = (cur_addr == end_addr) ? S_DONE : S_ISSUE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    busy      = (state != S_IDLE);
    scan_done = (state == S_DONE);
    rd_start  = (state == S_ISSUE) && rd_done;
  end

  // Scan bookkeeping; end test happens before the increment so 0xFF never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr  <= '0;
      end_addr  <= '0;
      offset    <= '0;
      rd_count  <= '0;
      range_err <= 1'b0;
    end else begin
      if (state == S_IDLE && scan_start) begin
        cur_addr  <= first_addr;
        end_addr  <= last_addr;
        offset    <= '0;
        rd_count  <= '0;
        range_err <= (first_addr > last_addr);
      end else if (state == S_STORE) begin
        rd_count <= rd_count + 9'd1;
        if (cur_addr != end_addr) begin
          cur_addr <= cur_addr + 8'd1;
          offset   <= offset + 8'd1;
        end
      end
    end
  end

  // Capture buffer write port (not reset).
  always_ff @(posedge clk) begin
    if (state == S_STORE)
      mem[offset] <= store_data;
  end

  // Registered readback port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rb_data <= '0;
    else        rb_data <= mem[rb_addr];
  end

endmodule

// File: tb/tb_adv7513_reg_scan.sv
// Self-checking bench for adv7513_reg_scan: a transaction-level read-block
// responder, a scan-level reference model checked every cycle, and directed
// scans with hand-computed expectations.
module tb_adv7513_reg_scan;

  logic       clk;
  logic       reset;
  logic       scan_start;
  logic [7:0] first_addr;
  logic [7:0] last_addr;
  logic       busy;
  logic       scan_done;
  logic       range_err;
  logic       timeout_err;
  logic [8:0] rd_count;
  logic       rd_start;
  logic [7:0] rd_addr;
  logic       rd_done;
  logic [7:0] rd_data;
  logic [7:0] rb_addr;
  logic [7:0] rb_data;

  adv7513_reg_scan #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .reset(reset), .scan_start(scan_start),
    .first_addr(first_addr), .last_addr(last_addr),
    .busy(busy), .scan_done(scan_done), .range_err(range_err),
    .timeout_err(timeout_err), .rd_count(rd_count),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_data(rd_data), .rb_addr(rb_addr), .rb_data(rb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Responder configuration
  int         hold = 2;       // sampled-high cycles after rd_start = hold-1
  int         lat = 3;        // cycles rd_done stays low
  int         hang_addr = -1; // address whose read never completes
  int         mode = 0;       // 0: addr^0x5A, 1: constant 0xA5
  logic [7:0] decoy = 8'hEE;
  logic       hung = 1'b0;

  function automatic logic [7:0] answer(input logic [7:0] a);
    return (mode == 1) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  // Downstream read block model
  initial begin
    logic [7:0] ra;
    rd_done = 1'b1;
    rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_start === 1'b1) begin
        ra = rd_addr;
        @(posedge clk); #1;
        rd_data = decoy;
        for (int k = 1; k < hold; k++) begin
          @(posedge clk); #1;
        end
        rd_done = 1'b0;
        hung = (int'(ra) == hang_addr);
        while (int'(ra) == hang_addr) @(posedge clk);
        hung = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(posedge clk); #1;
        end
        rd_data = answer(ra);
        rd_done = 1'b1;
      end
    end
  end

  // Scan-level reference model state
  logic [7:0] exp_q[$];
  logic [7:0] buf_model [0:255];
  int  exp_n = 0;
  int  last_count = 0;
  int  n_override = -1;
  bit  model_busy = 0;
  bit  was_busy = 0;
  bit  exp_range = 0;
  bit  exp_tmo = 0;
  bit  tmo_scan = 0;
  int  pulse_cnt = 0;
  int  done_cnt = 0;
  int  cyc = 0;
  int  accept_cyc = 0;
  int  done_cyc = 0;
  int  last_pulse_cyc = -100;

  // Compare process: every cycle against the scan-level model.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        exp_q.delete();
        model_busy = 0;
        last_count = 0;
        exp_range = 0;
        exp_tmo = 0;
        last_pulse_cyc = -100;
        check("rst_busy", busy, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_range_err", range_err, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_rd_start", rd_start, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rb_data", rb_data, 0);
      end else begin
        was_busy = model_busy;
        check("busy", busy, int'(model_busy));
        check("range_err", range_err, int'(exp_range));
        if (!(tmo_scan && was_busy)) check("timeout_err", timeout_err, int'(exp_tmo));
        if (rd_start) begin
          pulse_cnt++;
          check("rd_start_outside_scan", int'(was_busy), 1);
          check("rd_start_spacing", int'((cyc - last_pulse_cyc) >= 4), 1);
          last_pulse_cyc = cyc;
          if (exp_q.size() == 0) check("rd_start_extra", exp_q.size(), 1);
          else check("rd_addr", rd_addr, int'(exp_q.pop_front()));
        end
        if (was_busy) check("rd_count_bound", int'(int'(rd_count) <= exp_n), 1);
        else          check("rd_count_idle", rd_count, last_count);
        if (scan_done) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_outside_scan", int'(was_busy), 1);
          if (tmo_scan) check("done_timeout_err", timeout_err, 1);
          else          check("done_addrs_left", exp_q.size(), 0);
          check("done_rd_count", rd_count, exp_n);
          last_count = exp_n;
          exp_tmo = tmo_scan;
          exp_q.delete();
          model_busy = 0;
        end
        if (scan_start && !was_busy) begin
          exp_range = (first_addr > last_addr);
          exp_tmo = 0;
          exp_n = exp_range ? 0 : int'(last_addr) - int'(first_addr) + 1;
          if (n_override >= 0) exp_n = n_override;
          if (!exp_range)
            for (int a = int'(first_addr); a <= int'(last_addr); a++) begin
              exp_q.push_back(a[7:0]);
              buf_model[a - int'(first_addr)] = answer(a[7:0]);
            end
          accept_cyc = cyc;
          model_busy = 1;
        end
      end
    end
  end

  task automatic launch(input logic [7:0] f, input logic [7:0] l);
    @(posedge clk); #1;
    first_addr = f;
    last_addr = l;
    scan_start = 1'b1;
    pulse_cnt = 0;
    @(posedge clk); #1;
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    check("scan_done_seen", done_cnt - d0, 1);
  endtask

  task automatic rb_check(input string name, input int idx, input int expected);
    @(posedge clk); #1;
    rb_addr = idx[7:0];
    @(posedge clk); #1;
    check(name, rb_data, expected);
  endtask

  task automatic wait_rd_done_idle();
    for (int i = 0; i < 50 && rd_done !== 1'b1; i++) @(posedge clk);
    check("read_block_idle", rd_done, 1);
  endtask

  task automatic check_reset_outputs();
    check("r_busy", busy, 0);
    check("r_scan_done", scan_done, 0);
    check("r_range_err", range_err, 0);
    check("r_timeout_err", timeout_err, 0);
    check("r_rd_count", rd_count, 0);
    check("r_rd_start", rd_start, 0);
    check("r_rd_addr", rd_addr, 0);
    check("r_rb_data", rb_data, 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL global_time_limit: got timeout, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int d0;
    reset = 1'b0;
    scan_start = 1'b0;
    first_addr = 8'h00;
    last_addr = 8'h00;
    rb_addr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Full scan 0x10..0x13, data = addr ^ 0x5A
    d0 = done_cnt;
    launch(8'h10, 8'h13);
    wait_done(d0, 500);
    repeat (3) @(posedge clk);
    check("full_done_pulses", done_cnt - d0, 1);
    check("full_pulses", pulse_cnt, 4);
    check("full_rd_count", rd_count, 4);
    rb_check("full_rb0", 0, 8'h4A);
    rb_check("full_rb1", 1, 8'h4B);
    rb_check("full_rb2", 2, 8'h48);
    rb_check("full_rb3", 3, 8'h49);

    // Top-of-map boundary: 0xFE..0xFF, must not wrap to 0x00
    d0 = done_cnt;
    launch(8'hFE, 8'hFF);
    wait_done(d0, 300);
    check("top_pulses", pulse_cnt, 2);
    check("top_rd_count", rd_count, 2);
    rb_check("top_rb0", 0, 8'hA4);
    rb_check("top_rb1", 1, 8'hA5);

    // Single address 0x00, constant answer 0xA5
    mode = 1;
    d0 = done_cnt;
    launch(8'h00, 8'h00);
    wait_done(d0, 300);
    check("single_rd_count", rd_count, 1);
    rb_check("single_rb0", 0, 8'hA5);
    mode = 0;

    // Range error: no reads, done on the cycle right after the accepting cycle
    d0 = done_cnt;
    launch(8'h20, 8'h1F);
    wait_done(d0, 50);
    check("range_pulses", pulse_cnt, 0);
    check("range_err_set", range_err, 1);
    check("range_rd_count", rd_count, 0);
    check("range_done_latency", done_cyc - accept_cyc, 1);

    // Handshake: rd_done held high 3 cycles after rd_start with decoy data,
    // plus a scan_start pulse while busy that must be ignored
    hold = 4;
    d0 = done_cnt;
    launch(8'h30, 8'h32);
    repeat (6) @(posedge clk);
    #1;
    first_addr = 8'h00;
    last_addr = 8'h05;
    scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    wait_done(d0, 500);
    check("hs_pulses", pulse_cnt, 3);
    check("hs_rd_count", rd_count, 3);
    check("hs_range_cleared", range_err, 0);
    rb_check("hs_rb0", 0, 8'h6A);
    for (int i = 1; i < 3; i++) rb_check("hs_rb_model", i, int'(buf_model[i]));
    hold = 2;

    // Reset while waiting on the read of 0x03 in a 0x00..0x0F scan
    hang_addr = 3;
    launch(8'h00, 8'h0F);
    for (int i = 0; i < 200 && !hung; i++) @(posedge clk);
    check("hang_reached", hung, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    hang_addr = -1;
    wait_rd_done_idle();
    d0 = done_cnt;
    launch(8'h40, 8'h43);
    wait_done(d0, 500);
    check("post_rst_pulses", pulse_cnt, 4);
    check("post_rst_rd_count", rd_count, 4);
    for (int i = 0; i < 4; i++) rb_check("post_rst_rb", i, int'(buf_model[i]));

`ifdef ADV7513_SCAN_TIMEOUT_EN
    // Watchdog: 0x05 never completes, then S_ISSUE for 0x06 times out
    tmo_scan = 1;
    n_override = 2;
    hang_addr = 5;
    d0 = done_cnt;
    launch(8'h04, 8'h06);
    wait_done(d0, 600);
    check("tmo_err", timeout_err, 1);
    check("tmo_pulses", pulse_cnt, 2);
    check("tmo_rd_count", rd_count, 2);
    rb_check("tmo_rb0", 0, 8'h5E);
    rb_check("tmo_rb1", 1, 8'hFF);
    tmo_scan = 0;
    n_override = -1;
    hang_addr = -1;
    wait_rd_done_idle();
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
